// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types for the I2C master write controller.
//   i2c_ctrl_state_t : transaction sequencer states
//   i2c_phase_t      : quarter-period phase within one SCL bit
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_LOAD,
        ST_DATA,
        ST_DATA_ACK,
        ST_STOP
    } i2c_ctrl_state_t;

    // Q0/Q1: SCL low, Q2/Q3: SCL released
    typedef enum logic [1:0] {
        PH_Q0,
        PH_Q1,
        PH_Q2,
        PH_Q3
    } i2c_phase_t;

endpackage

// File: rtl/i2c_quarter_gen.sv
// i2c_quarter_gen: SCL quarter-period timebase.
// Counts 0..QUARTER-1 per quarter and steps a 2-bit phase (Q0..Q3) per bit.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   restart    - force counter and phase back to Q0 / count 0
//   hold       - freeze the counter (clock stretching)
//   phase      - current quarter phase (0..3)
//   phase_end  - one-cycle strobe on the last cycle of the current quarter
module i2c_quarter_gen #(
    parameter int DIV_LEN = 16,
    parameter int QUARTER = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       hold,
    output logic [1:0] phase,
    output logic       phase_end
);

    localparam logic [DIV_LEN-1:0] LAST = DIV_LEN'(QUARTER - 1);

    logic [DIV_LEN-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt   <= '0;
            phase <= '0;
        end else if (!hold) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign phase_end = !restart && !hold && (cnt == LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: I2C master write-transaction controller.
// Frames START, address byte (R/W=0), cmd_len data bytes from a ready/valid
// source with ACK checking, and STOP. Owns SDA/SCL for the whole transaction.
// Optional feature: define I2C_CLOCK_STRETCH_EN to honour slave clock
// stretching (quarter counter holds in Q2 while SCL is released but reads 0).
// Ports:
//   clk, rst                 - system clock, synchronous active-high reset
//   cmd_valid/cmd_ready      - command handshake (ready only in IDLE)
//   cmd_addr, cmd_len        - 7-bit target address, data byte count 0..15
//   wr_data/wr_valid/wr_ready- data byte source, taken when valid && ready
//   busy, done               - transaction active, one-cycle end pulse
//   nak, nak_idx             - abort status (0 = address, k = data byte k)
//   i2c_sda_i/_t/_o          - SDA drive value, tristate (1 = released), pad
//   i2c_scl_i/_t/_o          - SCL drive value, tristate (1 = released), pad
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int I2C_FREQ = 100_000,
    parameter int DIV_LEN  = 16,
    parameter int QUARTER  = CLK_FREQ / (4 * I2C_FREQ)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic       busy,
    output logic       done,
    output logic       nak,
    output logic [3:0] nak_idx,
    output logic       i2c_sda_i,
    output logic       i2c_sda_t,
    input  logic       i2c_sda_o,
    output logic       i2c_scl_i,
    output logic       i2c_scl_t,
    input  logic       i2c_scl_o
);

    i2c_ctrl_state_t state, state_next;
    i2c_phase_t      phase;

    logic [1:0] phase_raw;
    logic       phase_end;
    logic       bit_end;
    logic       restart;
    logic       hold;

    logic [3:0] len_q;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [3:0] byte_cnt;
    logic       ack_bit;
    logic       nak_q;
    logic [3:0] nak_idx_q;
    logic       done_q;

    logic       take_byte;
    logic       nak_set;

    i2c_quarter_gen #(
        .DIV_LEN (DIV_LEN),
        .QUARTER (QUARTER)
    ) u_quarter_gen (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .hold      (hold),
        .phase     (phase_raw),
        .phase_end (phase_end)
    );

    assign phase   = i2c_phase_t'(phase_raw);
    assign bit_end = phase_end && (phase == PH_Q3);

`ifdef I2C_CLOCK_STRETCH_EN
    // Slave stretches by keeping SCL low after we release it in Q2.
    assign hold = (phase == PH_Q2) && i2c_scl_t && !i2c_scl_o;
`else
    logic unused_scl_pad;
    assign unused_scl_pad = i2c_scl_o;
    assign hold           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        i2c_scl_t  = 1'b1;
        i2c_sda_t  = 1'b1;
        restart    = 1'b0;
        take_byte  = 1'b0;
        nak_set    = 1'b0;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        wr_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                restart   = 1'b1;
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // SDA falls at Q2 while SCL is high
                i2c_sda_t = (phase == PH_Q0) || (phase == PH_Q1);
                if (bit_end) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                i2c_scl_t = (phase == PH_Q2) || (phase == PH_Q3);
                i2c_sda_t = shreg[7];
                if (bit_end && (bit_cnt == 3'd7)) begin
                    state_next = ST_ADDR_ACK;
                end
            end
            ST_ADDR_ACK: begin
                i2c_scl_t = (phase == PH_Q2) || (phase == PH_Q3);
                if (bit_end) begin
                    if (ack_bit) begin
                        nak_set    = 1'b1;
                        state_next = ST_STOP;
                    end else if (len_q != 4'd0) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_LOAD: begin
                // Timebase parked at Q0 so DATA starts on a fresh bit
                restart   = 1'b1;
                i2c_scl_t = 1'b0;
                wr_ready  = 1'b1;
                if (wr_valid) begin
                    take_byte  = 1'b1;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                i2c_scl_t = (phase == PH_Q2) || (phase == PH_Q3);
                i2c_sda_t = shreg[7];
                if (bit_end && (bit_cnt == 3'd7)) begin
                    state_next = ST_DATA_ACK;
                end
            end
            ST_DATA_ACK: begin
                i2c_scl_t = (phase == PH_Q2) || (phase == PH_Q3);
                if (bit_end) begin
                    if (ack_bit) begin
                        nak_set    = 1'b1;
                        state_next = ST_STOP;
                    end else if (byte_cnt < len_q) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                i2c_scl_t = (phase != PH_Q0);
                i2c_sda_t = (phase == PH_Q3);
                if (bit_end) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            shreg     <= '1;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            ack_bit   <= 1'b1;
            nak_q     <= 1'b0;
            nak_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == ST_STOP) && bit_end;
            if ((state == ST_IDLE) && cmd_valid) begin
                len_q     <= cmd_len;
                shreg     <= {cmd_addr, 1'b0};
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                nak_q     <= 1'b0;
                nak_idx_q <= '0;
            end
            if (take_byte) begin
                shreg    <= wr_data;
                bit_cnt  <= '0;
                byte_cnt <= byte_cnt + 4'd1;
            end
            if (((state == ST_ADDR) || (state == ST_DATA)) && bit_end) begin
                shreg   <= {shreg[6:0], 1'b1};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if ((phase == PH_Q2) && phase_end) begin
                ack_bit <= i2c_sda_o;
            end
            if (nak_set) begin
                nak_q <= 1'b1;
                // byte_cnt already holds the 1-based index of the byte just sent
                nak_idx_q <= (state == ST_DATA_ACK) ? byte_cnt : 4'd0;
            end
        end
    end

    assign done      = done_q;
    assign nak       = nak_q;
    assign nak_idx   = nak_idx_q;
    assign i2c_sda_i = 1'b0;
    assign i2c_scl_i = 1'b0;

endmodule
